// File: rtl/wash_pkg.sv
// Shared phase codes, scheduler state encoding and load-value lookup for the
// washing-machine phase scheduler.
package wash_pkg;

  localparam logic [2:0] PH_IDLE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_HEAT  = 3'd2;
  localparam logic [2:0] PH_WASH  = 3'd3;
  localparam logic [2:0] PH_RINSE = 3'd4;
  localparam logic [2:0] PH_SPIN  = 3'd5;
  localparam logic [2:0] PH_FAULT = 3'd6;

  typedef enum logic [2:0] {
    SCH_IDLE    = 3'd0,
    SCH_RUN     = 3'd1,
    SCH_PAUSED  = 3'd2,
    SCH_DONE    = 3'd3,
    SCH_EXPIRED = 3'd4
  } sched_state_e;

  // Ticks to load on entry to a phase; IDLE, FAULT and the reserved code load 0.
  function automatic int unsigned phase_load(
    input logic [2:0]  code,
    input int unsigned wash_ticks,
    input int unsigned rinse_ticks,
    input int unsigned spin_ticks,
    input int unsigned fill_limit,
    input int unsigned heat_limit
  );
    int unsigned load_s;
    case (code)
      PH_FILL:  load_s = fill_limit;
      PH_HEAT:  load_s = heat_limit;
      PH_WASH:  load_s = wash_ticks;
      PH_RINSE: load_s = rinse_ticks;
      PH_SPIN:  load_s = spin_ticks;
      default:  load_s = 32'd0;
    endcase
    return load_s;
  endfunction

  function automatic logic is_run_phase(input logic [2:0] code);
    return (code >= PH_FILL) && (code <= PH_SPIN);
  endfunction

  function automatic logic is_watchdog_phase(input logic [2:0] code);
    return (code == PH_FILL) || (code == PH_HEAT);
  endfunction

endpackage

// File: rtl/wash_phase_scheduler_if.sv
// Controller-facing signal bundle of the phase scheduler: phase code and
// sensors towards the scheduler, completion/timeout status back.
interface wash_phase_scheduler_if #(
  parameter int CNT_W = 8
) ();
  logic [2:0]       state;
  logic             sig_Lid_Closed;
  logic             sig_Full;
  logic             sig_Temperature;
  logic             sig_Completed;
  logic             sig_Time_Out;
  logic [CNT_W-1:0] remaining;
  logic             phase_active;

  modport master (
    output state, sig_Lid_Closed, sig_Full, sig_Temperature,
    input  sig_Completed, sig_Time_Out, remaining, phase_active
  );

  modport slave (
    input  state, sig_Lid_Closed, sig_Full, sig_Temperature,
    output sig_Completed, sig_Time_Out, remaining, phase_active
  );
endinterface

// File: rtl/wash_phase_scheduler_prescaler.sv
// Divides the clock into phase ticks; counts only while enabled and can be
// cleared to restart the tick period.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count_r;

  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $error("tick_prescaler: TICK_DIV must be at least 2");
    end
  endgenerate

  assign tick = enable && (count_r == LAST);

  // Prescaler count: clear wins, wraps on tick, holds while disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (tick) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + PW'(1);
    end else begin
      count_r <= count_r;
    end
  end
endmodule

// File: rtl/wash_phase_scheduler.sv
// Phase timer/watchdog for the washing-machine controller: counts down timed
// phases (pausing on open lid) and guards fill/heat phases with a timeout.
module wash_phase_scheduler
  import wash_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int TICK_DIV    = 1000,
  parameter int WASH_TICKS  = 120,
  parameter int RINSE_TICKS = 60,
  parameter int SPIN_TICKS  = 40,
  parameter int FILL_LIMIT  = 30,
  parameter int HEAT_LIMIT  = 50
) (
  input  logic                  clock,
  input  logic                  reset_n,
  wash_phase_scheduler_if.slave bus
);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  generate
    if ((WASH_TICKS > CNT_MAX) || (RINSE_TICKS > CNT_MAX) || (SPIN_TICKS > CNT_MAX) ||
        (FILL_LIMIT > CNT_MAX) || (HEAT_LIMIT > CNT_MAX) ||
        (WASH_TICKS < 0) || (RINSE_TICKS < 0) || (SPIN_TICKS < 0) ||
        (FILL_LIMIT < 0) || (HEAT_LIMIT < 0)) begin : g_bad_ticks
      $error("wash_phase_scheduler: phase durations do not fit in CNT_W");
    end
  endgenerate

  logic [2:0]       state_q_r;
  sched_state_e     fsm_r;
  sched_state_e     fsm_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [CNT_W-1:0] load_s;
  logic             completed_r;
  logic             completed_next_s;
  logic             time_out_r;
  logic             time_out_next_s;
  logic             active_r;
  logic             active_next_s;
  logic             change_s;
  logic             presc_en_s;
  logic             tick_s;
  logic             cond_s;
  logic             last_s;

  assign change_s   = (bus.state != state_q_r);
  assign presc_en_s = (fsm_r == SCH_RUN) && !change_s;
  assign load_s     = CNT_W'(phase_load(bus.state, WASH_TICKS, RINSE_TICKS, SPIN_TICKS,
                                        FILL_LIMIT, HEAT_LIMIT));
  // A tick with one (or zero) ticks left ends the phase.
  assign last_s     = (cnt_r <= CNT_W'(1));

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (presc_en_s),
    .clear   (change_s),
    .tick    (tick_s)
  );

  // Watchdog release condition for the phase currently being timed.
  always_comb begin
    if (state_q_r == PH_FILL) begin
      cond_s = bus.sig_Full;
    end else if (state_q_r == PH_HEAT) begin
      cond_s = bus.sig_Temperature;
    end else begin
      cond_s = 1'b0;
    end
  end

  // Next-state and next-output logic of the scheduler FSM.
  always_comb begin
    fsm_next_s       = fsm_r;
    cnt_next_s       = cnt_r;
    completed_next_s = 1'b0;
    time_out_next_s  = time_out_r;
    if (change_s) begin
      fsm_next_s      = is_run_phase(bus.state) ? SCH_RUN : SCH_IDLE;
      cnt_next_s      = load_s;
      time_out_next_s = 1'b0;
    end else begin
      case (fsm_r)
        SCH_RUN: begin
          if (is_watchdog_phase(state_q_r)) begin
            if (cond_s) begin
              fsm_next_s = SCH_DONE;
            end else if (tick_s && last_s) begin
              fsm_next_s      = SCH_EXPIRED;
              cnt_next_s      = '0;
              time_out_next_s = 1'b1;
            end else if (tick_s) begin
              cnt_next_s = cnt_r - CNT_W'(1);
            end else begin
              cnt_next_s = cnt_r;
            end
          end else begin
            if (tick_s && last_s) begin
              fsm_next_s       = SCH_DONE;
              cnt_next_s       = '0;
              completed_next_s = 1'b1;
            end else begin
              cnt_next_s = tick_s ? (cnt_r - CNT_W'(1)) : cnt_r;
              fsm_next_s = bus.sig_Lid_Closed ? SCH_RUN : SCH_PAUSED;
            end
          end
        end
        SCH_PAUSED: begin
          if (bus.sig_Lid_Closed) begin
            fsm_next_s = SCH_RUN;
          end else begin
            fsm_next_s = SCH_PAUSED;
          end
        end
        default: begin
          fsm_next_s = fsm_r;
        end
      endcase
    end
    active_next_s = (fsm_next_s == SCH_RUN) || (fsm_next_s == SCH_PAUSED);
  end

  // State and registered-output update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q_r   <= PH_IDLE;
      fsm_r       <= SCH_IDLE;
      cnt_r       <= '0;
      completed_r <= 1'b0;
      time_out_r  <= 1'b0;
      active_r    <= 1'b0;
    end else begin
      state_q_r   <= bus.state;
      fsm_r       <= fsm_next_s;
      cnt_r       <= cnt_next_s;
      completed_r <= completed_next_s;
      time_out_r  <= time_out_next_s;
      active_r    <= active_next_s;
    end
  end

  assign bus.sig_Completed = completed_r;
  assign bus.sig_Time_Out  = time_out_r;
  assign bus.remaining     = cnt_r;
  assign bus.phase_active  = active_r;
endmodule

// File: doc/wash_phase_scheduler.md
Name: wash_phase_scheduler

Overview:
- Times each phase of the washing-machine program from the 3-bit controller `state`.
- Produces the `sig_Completed` pulse and `sig_Time_Out` level that the controller consumes.
- Timed phases (WASH/RINSE/SPIN) run a programmable countdown that pauses while the lid is open.
- Fill/heat phases (FILL/HEAT) run a watchdog that expires if the water level or temperature condition is not met in time.
- Sits beside the controller at microcontroller top level, closing the loop from the controller's `state` back to the controller's inputs.

Parameters:
- CNT_W, 8, width of phase counter and `remaining` output
- TICK_DIV, 1000, clock cycles per phase tick (>=2)
- WASH_TICKS, 120, WASH duration in ticks
- RINSE_TICKS, 60, RINSE duration in ticks
- SPIN_TICKS, 40, SPIN duration in ticks
- FILL_LIMIT, 30, FILL watchdog limit in ticks
- HEAT_LIMIT, 50, HEAT watchdog limit in ticks

Ports:
- clock, in, 1, system clock, rising edge
- reset_n, in, 1, asynchronous active-low reset
- state, in, 3, controller phase code
- sig_Lid_Closed, in, 1, 1 = lid closed
- sig_Full, in, 1, water level reached
- sig_Temperature, in, 1, target temperature reached
- sig_Completed, out, 1, one-cycle pulse when a timed phase finishes
- sig_Time_Out, out, 1, level, FILL/HEAT watchdog expired
- remaining, out, CNT_W, ticks left in current phase
- phase_active, out, 1, counter running (RUN or PAUSED)

Behaviour:
- Phase codes: 0 IDLE, 1 FILL, 2 HEAT, 3 WASH, 4 RINSE, 5 SPIN, 6 FAULT, 7 reserved. Code 7 is treated as FAULT.
- Clock and reset:
  - Single clock.
  - Reset is asynchronous, active-low (`reset_n`).
  - On reset: `state_q` = 0, internal FSM = IDLE, prescaler = 0, counter = 0, all outputs 0.
- Phase change detection:
  - `state_q` registers `state` every cycle. A phase change is `state != state_q`.
  - The edge that detects the change (E0) loads: prescaler = 0, counter = the phase's ticks/limit (0 for IDLE/FAULT).
  - The same edge sets FSM = RUN for codes 1-5, else IDLE, clears `sig_Time_Out`, and suppresses `sig_Completed`.
  - A phase change mid-run aborts silently; no completion pulse is issued.
- Internal FSM states: IDLE, RUN, PAUSED, DONE, EXPIRED.
- Tick generation:
  - A tick occurs when FSM = RUN and prescaler = TICK_DIV-1.
  - On a tick, the prescaler wraps to 0. Otherwise the prescaler increments in RUN and holds in every other state.
  - First tick is at edge E0+TICK_DIV.
- Timed phases (3, 4, 5):
  - RUN -> PAUSED when `sig_Lid_Closed` = 0. PAUSED -> RUN when it returns to 1.
  - Prescaler and counter hold while PAUSED, and resume from the held value.
  - Each tick decrements the counter. The edge that makes the counter 0 sets FSM = DONE and raises `sig_Completed` for exactly one cycle.
  - Completion therefore occurs at edge E0+N*TICK_DIV.
  - A duration of 0 completes on the first tick.
  - DONE holds until the next phase change; no further pulses.
- Watchdog phases (1, 2):
  - Ticks run regardless of the lid.
  - If the condition (`sig_Full` for FILL, `sig_Temperature` for HEAT) is 1 in any RUN cycle, FSM -> DONE, the counter freezes, and no pulse is issued.
  - If the counter reaches 0 without the condition, FSM -> EXPIRED and `sig_Time_Out` = 1.
  - `sig_Time_Out` holds until the next phase change.
  - If the condition and expiry occur in the same cycle, the condition wins: DONE, no timeout.
- Outputs:
  - `remaining` = counter value, registered.
  - `phase_active` = 1 in RUN or PAUSED.
- Counter arithmetic: unsigned, never underflows below 0. Parameters must fit in CNT_W; this is checked at elaboration.

Decomposition:
- `wash_pkg` holds:
  - the phase code constants (IDLE..FAULT)
  - the scheduler FSM state enum
  - a function that maps a phase code to its load value
- One natural sub-module, `tick_prescaler`: enable and clear inputs, tick output, TICK_DIV parameter.

Test Plan (all with TICK_DIV=4, WASH_TICKS=3, FILL_LIMIT=2):
- Basic completion: after reset, `state` 0 -> 3 at E0 with lid closed -> `remaining` 3,2,1,0 at E0+4, +8, +12; `sig_Completed` high exactly one cycle after E0+12; no second pulse.
- Lid pause: WASH with lid opened for 10 cycles after E0+5 -> `remaining` holds at 2; `sig_Completed` delayed to E0+22.
- Fill watchdog expiry: `state` = 1 with `sig_Full` = 0 -> `sig_Time_Out` rises at E0+8 and stays high; `state` -> 6 clears it the next edge.
- Fill satisfied: `sig_Full` = 1 at E0+3 -> no timeout, `phase_active` = 0, `remaining` frozen at 2.
- Simultaneous condition and expiry: `sig_Full` asserted in the cycle of the second tick -> `sig_Time_Out` stays 0.
- Abort and reset: `state` 3 -> 4 at E0+6 -> no `sig_Completed`, `remaining` reloads to RINSE_TICKS. `reset_n` low mid-phase -> all outputs 0 immediately, without waiting for a clock edge.
